prbs_pattern_gen: RTL

PRBS_PATTERN_GEN -- requirements
Module: prbs_pattern_gen

---
 rtl/prbs_pkg.sv | 60 ++++++
 rtl/prbs_pattern_gen_if.sv | 24 ++
 rtl/prbs_lfsr_step.sv | 36 +++
 rtl/prbs_pattern_gen.sv | 136 +++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types, tap constants and helpers for the PRBS pattern generator.
// Provides: state_t, mode_t, tap_a/tap_b/len_mask/seed_fix.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PATT = 2'd1,
        ST_PRBS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS23 = 2'd2,
        MODE_PRBS31 = 2'd3
    } mode_t;

    localparam logic [4:0] TAP7_A  = 5'd7;
    localparam logic [4:0] TAP7_B  = 5'd6;
    localparam logic [4:0] TAP15_A = 5'd15;
    localparam logic [4:0] TAP15_B = 5'd14;
    localparam logic [4:0] TAP23_A = 5'd23;
    localparam logic [4:0] TAP23_B = 5'd18;
    localparam logic [4:0] TAP31_A = 5'd31;
    localparam logic [4:0] TAP31_B = 5'd28;

    // The high tap equals the polynomial order L.
    function automatic logic [4:0] tap_a(mode_t m);
        unique case (m)
            MODE_PRBS7:  return TAP7_A;
            MODE_PRBS15: return TAP15_A;
            MODE_PRBS23: return TAP23_A;
            default:     return TAP31_A;
        endcase
    endfunction

    function automatic logic [4:0] tap_b(mode_t m);
        unique case (m)
            MODE_PRBS7:  return TAP7_B;
            MODE_PRBS15: return TAP15_B;
            MODE_PRBS23: return TAP23_B;
            default:     return TAP31_B;
        endcase
    endfunction

    // Low-L-bit mask; for L=31 the shift wraps to 0 and the subtract gives all ones.
    function automatic logic [30:0] len_mask(mode_t m);
        logic [30:0] one;
        one = 31'd1;
        return (one << tap_a(m)) - 31'd1;
    endfunction

    // An all-zero LFSR never leaves zero, so substitute all ones.
    function automatic logic [30:0] seed_fix(logic [30:0] s, mode_t m);
        logic [30:0] masked;
        masked = s & len_mask(m);
        return (masked == '0) ? len_mask(m) : masked;
    endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// Output stream handshake of the PRBS pattern generator.
// Signals: out_valid, out_ready, out_data[DATA_W], phase (0=pattern, 1=PRBS).
interface prbs_pattern_gen_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              phase;

    modport master (
        output out_valid,
        output out_data,
        output phase,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  phase,
        output out_ready
    );
endinterface

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_W-step Fibonacci LFSR advance.
// Ports: state/mode in; state_next and packed word (first bit in MSB) out.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [30:0]       state,
    input  mode_t             mode,
    output logic [30:0]       state_next,
    output logic [DATA_W-1:0] word
);

    logic [4:0]  ia;
    logic [4:0]  ib;
    logic [30:0] mask;

    assign ia   = tap_a(mode) - 5'd1;
    assign ib   = tap_b(mode) - 5'd1;
    assign mask = len_mask(mode);

    always_comb begin
        logic [30:0] s;
        logic        nb;
        s    = state;
        nb   = 1'b0;
        word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            nb = s[ia] ^ s[ib];
            s  = {s[29:0], nb} & mask;
            word[DATA_W-1-i] = nb;
        end
        state_next = s;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Burst generator: n repetitions of a preamble pattern, then endless PRBS.
// Ports: clk, arst, start, stop, n, pattern, mode, seed, dout (stream), busy.
module prbs_pattern_gen
    import prbs_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PATT_NUM = 4,
    parameter int CNT_W    = 5
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [CNT_W-1:0]           n,
    input  logic [DATA_W*PATT_NUM-1:0] pattern,
    input  logic [1:0]                 mode,
    input  logic [30:0]                seed,
    prbs_pattern_gen_if.master         dout,
    output logic                       busy
);

    localparam int IDX_W = (PATT_NUM > 1) ? $clog2(PATT_NUM) : 1;

    state_t                     state;
    logic [DATA_W*PATT_NUM-1:0] patt_q;
    logic [CNT_W-1:0]           n_q;
    logic [CNT_W-1:0]           rep_cnt;
    mode_t                      mode_q;
    logic [30:0]                lfsr;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_inc;
    logic [DATA_W-1:0]          next_word;

    logic [30:0]       step_in;
    mode_t             step_mode;
    logic [30:0]       step_next;
    logic [DATA_W-1:0] step_word;
    logic              xfer;

    assign busy    = (state != ST_IDLE);
    assign xfer    = dout.out_valid & dout.out_ready;
    assign idx_inc = idx + IDX_W'(1);

    // In IDLE the step unit works on the incoming seed so an n==0 start
    // can present its first PRBS word on the very next cycle.
    assign step_mode = (state == ST_IDLE) ? mode_t'(mode) : mode_q;
    assign step_in   = (state == ST_IDLE) ? seed_fix(seed, mode_t'(mode))
                                          : lfsr;

    always_comb begin
        next_word = '0;
        for (int k = 0; k < PATT_NUM; k++) begin
            if (idx_inc == IDX_W'(k)) begin
                next_word = patt_q[DATA_W*k +: DATA_W];
            end
        end
    end

    prbs_lfsr_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .state     (step_in),
        .mode      (step_mode),
        .state_next(step_next),
        .word      (step_word)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state          <= ST_IDLE;
            dout.out_valid <= 1'b0;
            dout.out_data  <= '0;
            dout.phase     <= 1'b0;
            patt_q         <= '0;
            n_q            <= '0;
            rep_cnt        <= '0;
            mode_q         <= MODE_PRBS7;
            lfsr           <= '0;
            idx            <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        patt_q         <= pattern;
                        n_q            <= n;
                        mode_q         <= mode_t'(mode);
                        rep_cnt        <= '0;
                        idx            <= '0;
                        dout.out_valid <= 1'b1;
                        if (n != '0) begin
                            state         <= ST_PATT;
                            dout.out_data <= pattern[DATA_W-1:0];
                            dout.phase    <= 1'b0;
                            lfsr          <= step_in;
                        end else begin
                            state         <= ST_PRBS;
                            dout.out_data <= step_word;
                            dout.phase    <= 1'b1;
                            lfsr          <= step_next;
                        end
                    end
                end
                ST_PATT, ST_PRBS: begin
                    if (stop) begin
                        state          <= ST_IDLE;
                        dout.out_valid <= 1'b0;
                        dout.out_data  <= '0;
                        dout.phase     <= 1'b0;
                    end else if (xfer) begin
                        if (state == ST_PRBS) begin
                            dout.out_data <= step_word;
                            lfsr          <= step_next;
                        end else if (idx != IDX_W'(PATT_NUM - 1)) begin
                            idx           <= idx_inc;
                            dout.out_data <= next_word;
                        end else if (rep_cnt == n_q - CNT_W'(1)) begin
                            state         <= ST_PRBS;
                            dout.out_data <= step_word;
                            dout.phase    <= 1'b1;
                            lfsr          <= step_next;
                        end else begin
                            rep_cnt       <= rep_cnt + CNT_W'(1);
                            idx           <= '0;
                            dout.out_data <= patt_q[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    dout.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
